// File: rtl/decode_stage.sv
// RV32I instruction decode stage.
// Holds the 32x32 register file (one writeback port, write-through bypass on
// both read ports), decodes control signals and immediates for the supported
// subset (R-type ALU, I-type ALU, lw, sw, beq, jal) and registers everything
// into the ID/EX pipeline register. Unsupported encodings, including the
// all-zero IF/ID reset value, become bubbles with IllegalE raised.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    input  logic            StallE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic            IllegalE
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Maps funct3 of an ALU instruction to {supported, ALU control}.
    // funct3=011 (sltu) has no ALU operation here and is reported unsupported.
    function automatic logic [3:0] aluFromFunct3(input logic [2:0] f3);
        case (f3)
            3'b000:  aluFromFunct3 = {1'b1, 3'b000};   // add
            3'b111:  aluFromFunct3 = {1'b1, 3'b010};   // and
            3'b110:  aluFromFunct3 = {1'b1, 3'b011};   // or
            3'b100:  aluFromFunct3 = {1'b1, 3'b100};   // xor
            3'b010:  aluFromFunct3 = {1'b1, 3'b101};   // slt
            3'b001:  aluFromFunct3 = {1'b1, 3'b110};   // sll
            3'b101:  aluFromFunct3 = {1'b1, 3'b111};   // srl
            default: aluFromFunct3 = {1'b0, 3'b000};
        endcase
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic [3:0]      aluDec_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic [XLEN-1:0] regs_r [NREGS];

    logic            regWrite_s;
    logic [1:0]      resultSrc_s;
    logic            memWrite_s;
    logic            jump_s;
    logic            branch_s;
    logic [2:0]      aluControl_s;
    logic            aluSrc_s;
    logic [XLEN-1:0] immExt_s;
    logic            illegal_s;

    assign opcode_s = InstrD[6:0];
    assign rd_s     = InstrD[11:7];
    assign funct3_s = InstrD[14:12];
    assign rs1_s    = InstrD[19:15];
    assign rs2_s    = InstrD[24:20];
    assign funct7_s = InstrD[31:25];
    assign aluDec_s = aluFromFunct3(funct3_s);

    // Register file write port; x0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            regs_r[RdW] <= ResultW;
        end
    end

    // Read ports with write-through bypass so a same-cycle WB value is seen.
    always_comb begin
        rd1_s = regs_r[rs1_s];
        rd2_s = regs_r[rs2_s];
        if (rs1_s == 5'd0) begin
            rd1_s = '0;
        end else if (RegWriteW && (RdW == rs1_s)) begin
            rd1_s = ResultW;
        end else begin
            rd1_s = regs_r[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rd2_s = '0;
        end else if (RegWriteW && (RdW == rs2_s)) begin
            rd2_s = ResultW;
        end else begin
            rd2_s = regs_r[rs2_s];
        end
    end

    // Main decoder: control signals and immediate; anything unrecognised is a bubble.
    always_comb begin
        regWrite_s   = 1'b0;
        resultSrc_s  = 2'b00;
        memWrite_s   = 1'b0;
        jump_s       = 1'b0;
        branch_s     = 1'b0;
        aluControl_s = ALU_ADD;
        aluSrc_s     = 1'b0;
        immExt_s     = '0;
        illegal_s    = 1'b0;
        case (opcode_s)
            OP_R: begin
                if ((funct7_s == 7'b0000000) && aluDec_s[3]) begin
                    regWrite_s   = 1'b1;
                    aluControl_s = aluDec_s[2:0];
                end else if ((funct7_s == 7'b0100000) && (funct3_s == 3'b000)) begin
                    regWrite_s   = 1'b1;
                    aluControl_s = ALU_SUB;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_IALU: begin
                // Shifts carry funct7 in imm[11:5]; only the logical (zero) form is supported.
                if (aluDec_s[3] && (((funct3_s != 3'b001) && (funct3_s != 3'b101))
                                    || (funct7_s == 7'b0000000))) begin
                    regWrite_s   = 1'b1;
                    aluSrc_s     = 1'b1;
                    aluControl_s = aluDec_s[2:0];
                    immExt_s     = {{20{InstrD[31]}}, InstrD[31:20]};
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_LW: begin
                if (funct3_s == 3'b010) begin
                    regWrite_s  = 1'b1;
                    resultSrc_s = 2'b01;
                    aluSrc_s    = 1'b1;
                    immExt_s    = {{20{InstrD[31]}}, InstrD[31:20]};
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_SW: begin
                if (funct3_s == 3'b010) begin
                    memWrite_s = 1'b1;
                    aluSrc_s   = 1'b1;
                    immExt_s   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_BEQ: begin
                if (funct3_s == 3'b000) begin
                    branch_s     = 1'b1;
                    aluControl_s = ALU_SUB;
                    immExt_s     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                                    InstrD[11:8], 1'b0};
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_JAL: begin
                jump_s      = 1'b1;
                regWrite_s  = 1'b1;
                resultSrc_s = 2'b10;
                immExt_s    = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                               InstrD[30:21], 1'b0};
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // ID/EX pipeline register: reset and flush load a zero bubble, stall holds.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= 3'b000;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            IllegalE    <= 1'b0;
        end else if (!StallE) begin
            RegWriteE   <= regWrite_s;
            ResultSrcE  <= resultSrc_s;
            MemWriteE   <= memWrite_s;
            JumpE       <= jump_s;
            BranchE     <= branch_s;
            ALUControlE <= aluControl_s;
            ALUSrcE     <= aluSrc_s;
            RD1E        <= rd1_s;
            RD2E        <= rd2_s;
            ImmExtE     <= immExt_s;
            Rs1E        <= rs1_s;
            Rs2E        <= rs2_s;
            RdE         <= rd_s;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            IllegalE    <= illegal_s;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expected values.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE, StallE;
    logic [4:0]  RdW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int checkCount = 0;
    int errorCount = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .FlushE(FlushE), .StallE(StallE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .IllegalE(IllegalE)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBubble(input string tag);
        checkVal({tag, ".RegWriteE"},  32'(RegWriteE),  32'd0);
        checkVal({tag, ".MemWriteE"},  32'(MemWriteE),  32'd0);
        checkVal({tag, ".JumpE"},      32'(JumpE),      32'd0);
        checkVal({tag, ".BranchE"},    32'(BranchE),    32'd0);
        checkVal({tag, ".ResultSrcE"}, 32'(ResultSrcE), 32'd0);
        checkVal({tag, ".IllegalE"},   32'(IllegalE),   32'd0);
        checkVal({tag, ".RdE"},        32'(RdE),        32'd0);
        checkVal({tag, ".Rs1E"},       32'(Rs1E),       32'd0);
        checkVal({tag, ".Rs2E"},       32'(Rs2E),       32'd0);
    endtask

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    initial begin
        rst = 1'b1; InstrD = 32'h005283B3; PCD = 32'h0000_0040; PCPlus4D = 32'h0000_0044;
        RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0; FlushE = 1'b0; StallE = 1'b0;

        // 1: reset, then every register reads zero
        tick(); tick();
        checkBubble("reset");
        checkVal("reset.PCE", PCE, 32'd0);
        checkVal("reset.ImmExtE", ImmExtE, 32'd0);
        checkVal("reset.ALUControlE", 32'(ALUControlE), 32'd0);
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            InstrD = encR(7'b0, 5'(i), 5'(i), 3'b000, 5'd0);
            tick();
            checkVal($sformatf("rf0.RD1E.x%0d", i), RD1E, 32'd0);
            checkVal($sformatf("rf0.RD2E.x%0d", i), RD2E, 32'd0);
            checkVal($sformatf("rf0.Rs1E.x%0d", i), 32'(Rs1E), 32'(i));
        end

        // 2: same-cycle write-through, then read from the array
        InstrD = 32'h005283B3; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'hDEADBEEF;
        tick();
        checkVal("byp.RD1E", RD1E, 32'hDEADBEEF);
        checkVal("byp.RD2E", RD2E, 32'hDEADBEEF);
        checkVal("byp.ALUControlE", 32'(ALUControlE), 32'd0);
        checkVal("byp.RegWriteE", 32'(RegWriteE), 32'd1);
        checkVal("byp.RdE", 32'(RdE), 32'd7);
        checkVal("byp.ALUSrcE", 32'(ALUSrcE), 32'd0);
        checkVal("byp.IllegalE", 32'(IllegalE), 32'd0);
        RegWriteW = 1'b0;
        tick();
        checkVal("rf.RD1E", RD1E, 32'hDEADBEEF);

        // 3: writes to x0 are ignored, both bypassed and stored
        InstrD = encR(7'b0, 5'd0, 5'd0, 3'b000, 5'd0);
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h0000_1234;
        tick();
        checkVal("x0byp.RD1E", RD1E, 32'd0);
        RegWriteW = 1'b0;
        tick();
        checkVal("x0.RD1E", RD1E, 32'd0);

        // 4: sw with rs2 bypass, then beq
        InstrD = 32'hFE20AE23; RegWriteW = 1'b1; RdW = 5'd2; ResultW = 32'h0000_55AA;
        tick();
        RegWriteW = 1'b0;
        checkVal("sw.MemWriteE", 32'(MemWriteE), 32'd1);
        checkVal("sw.ALUSrcE", 32'(ALUSrcE), 32'd1);
        checkVal("sw.ImmExtE", ImmExtE, 32'hFFFFFFFC);
        checkVal("sw.RegWriteE", 32'(RegWriteE), 32'd0);
        checkVal("sw.RD2E", RD2E, 32'h0000_55AA);
        checkVal("sw.Rs1E", 32'(Rs1E), 32'd1);
        checkVal("sw.Rs2E", 32'(Rs2E), 32'd2);
        InstrD = 32'hFE000CE3;
        tick();
        checkVal("beq.BranchE", 32'(BranchE), 32'd1);
        checkVal("beq.ALUControlE", 32'(ALUControlE), 32'd1);
        checkVal("beq.ImmExtE", ImmExtE, 32'hFFFFFFF8);
        checkVal("beq.RegWriteE", 32'(RegWriteE), 32'd0);

        // 5: jal, then flush
        InstrD = 32'h010000EF; PCD = 32'h0000_0100; PCPlus4D = 32'h0000_0104;
        tick();
        checkVal("jal.JumpE", 32'(JumpE), 32'd1);
        checkVal("jal.RegWriteE", 32'(RegWriteE), 32'd1);
        checkVal("jal.ResultSrcE", 32'(ResultSrcE), 32'd2);
        checkVal("jal.ImmExtE", ImmExtE, 32'h0000_0010);
        checkVal("jal.PCE", PCE, 32'h0000_0100);
        checkVal("jal.PCPlus4E", PCPlus4E, 32'h0000_0104);
        checkVal("jal.RdE", 32'(RdE), 32'd1);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        checkBubble("flush");

        // other formats: lw, sub, addi, slli, slti, xori, srai (unsupported)
        InstrD = encI(12'd8, 5'd5, 3'b010, 5'd6, 7'b0000011);
        tick();
        checkVal("lw.ResultSrcE", 32'(ResultSrcE), 32'd1);
        checkVal("lw.ALUSrcE", 32'(ALUSrcE), 32'd1);
        checkVal("lw.ImmExtE", ImmExtE, 32'd8);
        checkVal("lw.RegWriteE", 32'(RegWriteE), 32'd1);
        checkVal("lw.RD1E", RD1E, 32'hDEADBEEF);
        InstrD = encR(7'b0100000, 5'd5, 5'd5, 3'b000, 5'd8);
        tick();
        checkVal("sub.ALUControlE", 32'(ALUControlE), 32'd1);
        checkVal("sub.RegWriteE", 32'(RegWriteE), 32'd1);
        InstrD = encI(12'hFFF, 5'd1, 3'b000, 5'd3, 7'b0010011);
        tick();
        checkVal("addi.ImmExtE", ImmExtE, 32'hFFFFFFFF);
        checkVal("addi.ALUSrcE", 32'(ALUSrcE), 32'd1);
        checkVal("addi.ALUControlE", 32'(ALUControlE), 32'd0);
        InstrD = encI(12'd3, 5'd1, 3'b001, 5'd4, 7'b0010011);
        tick();
        checkVal("slli.ALUControlE", 32'(ALUControlE), 32'd6);
        checkVal("slli.ImmExtE", ImmExtE, 32'd3);
        InstrD = encI(12'd5, 5'd1, 3'b010, 5'd4, 7'b0010011);
        tick();
        checkVal("slti.ALUControlE", 32'(ALUControlE), 32'd5);
        InstrD = encI(12'd5, 5'd1, 3'b100, 5'd4, 7'b0010011);
        tick();
        checkVal("xori.ALUControlE", 32'(ALUControlE), 32'd4);
        InstrD = encI(12'h403, 5'd1, 3'b101, 5'd4, 7'b0010011);
        tick();
        checkVal("srai.IllegalE", 32'(IllegalE), 32'd1);
        checkVal("srai.RegWriteE", 32'(RegWriteE), 32'd0);
        checkVal("srai.RdE", 32'(RdE), 32'd4);

        // 6: stall holds ID/EX while regfile still writes
        InstrD = 32'hFE20AE23;
        tick();
        StallE = 1'b1;
        RegWriteW = 1'b1; RdW = 5'd9; ResultW = 32'h0000_0099;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       InstrD = 32'h005283B3;
                1:       InstrD = 32'h010000EF;
                default: InstrD = 32'hFE000CE3;
            endcase
            tick();
            RegWriteW = 1'b0;
            checkVal($sformatf("stall%0d.MemWriteE", k), 32'(MemWriteE), 32'd1);
            checkVal($sformatf("stall%0d.ImmExtE", k), ImmExtE, 32'hFFFFFFFC);
            checkVal($sformatf("stall%0d.RegWriteE", k), 32'(RegWriteE), 32'd0);
            checkVal($sformatf("stall%0d.JumpE", k), 32'(JumpE), 32'd0);
            checkVal($sformatf("stall%0d.BranchE", k), 32'(BranchE), 32'd0);
            checkVal($sformatf("stall%0d.RdE", k), 32'(RdE), 32'd28);
        end
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0; StallE = 1'b0;
        checkBubble("flushstall");
        InstrD = encR(7'b0, 5'd9, 5'd0, 3'b000, 5'd0);
        tick();
        checkVal("stallwr.RD2E", RD2E, 32'h0000_0099);
        InstrD = 32'hFFFFFFFF;
        tick();
        checkVal("ones.IllegalE", 32'(IllegalE), 32'd1);
        checkVal("ones.RegWriteE", 32'(RegWriteE), 32'd0);
        checkVal("ones.MemWriteE", 32'(MemWriteE), 32'd0);
        InstrD = 32'h0000_0000;
        tick();
        checkVal("zero.IllegalE", 32'(IllegalE), 32'd1);
        checkVal("zero.RegWriteE", 32'(RegWriteE), 32'd0);

        // reset mid-stream discards the slot and clears the register file
        InstrD = 32'h010000EF;
        tick();
        checkVal("prerst.JumpE", 32'(JumpE), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkBubble("midrst");
        InstrD = encR(7'b0, 5'd9, 5'd5, 3'b000, 5'd0);
        tick();
        checkVal("midrst.RD1E", RD1E, 32'd0);
        checkVal("midrst.RD2E", RD2E, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
